gf2_poly_div: RTL and testbench



---
 rtl/gf2_pkg.sv | 38 +++
 rtl/gf2_poly_div_deg_enc.sv | 13 +
 rtl/gf2_poly_div.sv | 127 ++++++++++++
 tb/tb_gf2_poly_div.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/gf2_pkg.sv
// Shared types, widths and helper functions for the GF(2) polynomial divider.
package gf2_pkg;

  localparam int unsigned N    = 117;
  localparam int unsigned DW   = 2 * N - 1;
  localparam int unsigned RW   = N - 1;
  localparam int unsigned DEGW = $clog2(N);
  localparam int unsigned CW   = $clog2(2 * N);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  typedef struct packed {
    logic          q;
    logic [RW-1:0] r;
  } step_t;

  // Index of the highest set coefficient; 0 for the zero polynomial.
  function automatic logic [DEGW-1:0] deg_of(input logic [N-1:0] b);
    logic [DEGW-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (b[i]) d = DEGW'(i);
    end
    return d;
  endfunction

  // One long-division step; coefficient d of the shifted remainder is cancelled.
  function automatic step_t gf2_step(input logic [RW-1:0] r, input logic din,
                                     input logic [N-1:0] b, input logic [DEGW-1:0] d);
    logic [N-1:0] t;
    step_t        s;
    t   = {r, din};
    s.q = t[d];
    s.r = RW'(t ^ (s.q ? b : '0));
    return s;
  endfunction

endpackage

// File: rtl/gf2_poly_div_deg_enc.sv
// Priority encoder: degree of an N-bit polynomial plus a zero flag.
module gf2_deg_enc
  import gf2_pkg::*;
(
  input  logic [N-1:0]    b,
  output logic [DEGW-1:0] d_c,
  output logic            zero_c
);

  assign d_c    = deg_of(b);
  assign zero_c = (b == '0);

endmodule

// File: rtl/gf2_poly_div.sv
// Sequential MSB-first GF(2) long divider: D = Q*B ^ R, deg R < deg B.
// GF2_DIV_RADIX4_EN selects two chained division steps per cycle.
module gf2_poly_div
  import gf2_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [N-1:0]  divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [RW-1:0] remainder,
  output logic          div_by_zero
);

`ifdef GF2_DIV_RADIX4_EN
  localparam int unsigned CYC = (DW + 1) / 2;
`else
  localparam int unsigned CYC = DW;
`endif

  state_t          state, state_nx;
  logic [DW-1:0]   ds, ds_nx;
  logic [N-1:0]    b_q, b_nx;
  logic [DEGW-1:0] d_q, d_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [DW-1:0]   q_nx;
  logic [RW-1:0]   r_nx;
  logic            dbz_nx;
  logic [DEGW-1:0] enc_d;
  logic            enc_zero;
  step_t           s1;
`ifdef GF2_DIV_RADIX4_EN
  step_t           s2;
`endif

  gf2_deg_enc u_deg_enc (
    .b      (divisor),
    .d_c    (enc_d),
    .zero_c (enc_zero)
  );

  // Next-state and datapath update.
  always_comb begin
    state_nx = state;
    ds_nx    = ds;
    b_nx     = b_q;
    d_nx     = d_q;
    cnt_nx   = cnt;
    q_nx     = quotient;
    r_nx     = remainder;
    dbz_nx   = div_by_zero;
    s1       = gf2_step(remainder, ds[DW-1], b_q, d_q);
`ifdef GF2_DIV_RADIX4_EN
    s2       = gf2_step(s1.r, ds[DW-2], b_q, d_q);
`endif
    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          ds_nx    = dividend;
          b_nx     = divisor;
          d_nx     = enc_d;
          cnt_nx   = CW'(CYC);
          q_nx     = '0;
          r_nx     = '0;
          dbz_nx   = enc_zero;
          state_nx = enc_zero ? DONE : DIV;
        end
      end
      DIV: begin
`ifdef GF2_DIV_RADIX4_EN
        // Odd dividend length: the first cycle consumes a single bit.
        if (cnt == CW'(CYC)) begin
          r_nx  = s1.r;
          q_nx  = {quotient[DW-2:0], s1.q};
          ds_nx = ds << 1;
        end else begin
          r_nx  = s2.r;
          q_nx  = {quotient[DW-3:0], s1.q, s2.q};
          ds_nx = ds << 2;
        end
`else
        r_nx  = s1.r;
        q_nx  = {quotient[DW-2:0], s1.q};
        ds_nx = ds << 1;
`endif
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ds          <= '0;
      b_q         <= '0;
      d_q         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
    end else begin
      state       <= state_nx;
      ds          <= ds_nx;
      b_q         <= b_nx;
      d_q         <= d_nx;
      cnt         <= cnt_nx;
      quotient    <= q_nx;
      remainder   <= r_nx;
      div_by_zero <= dbz_nx;
      in_ready    <= (state_nx == IDLE);
      out_valid   <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_gf2_poly_div.sv
// Directed and product-based checks for the GF(2) polynomial divider.
module tb_gf2_poly_div;
  import gf2_pkg::*;

`ifdef GF2_DIV_RADIX4_EN
  localparam int LAT_NZ = (DW + 1) / 2 + 1;
`else
  localparam int LAT_NZ = DW + 1;
`endif
  localparam int TMO  = 400;
  localparam int NRND = 30;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [N-1:0]  divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [RW-1:0] remainder;
  logic          div_by_zero;

  int n_chk  = 0;
  int n_fail = 0;

  gf2_poly_div dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] rnd_n();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return N'(t);
  endfunction

  function automatic logic [DW-1:0] clmul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [DW-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) begin
      if (b[i]) p = p ^ (DW'(a) << i);
    end
    return p;
  endfunction

  function automatic int deg(input logic [N-1:0] b);
    int d;
    d = 0;
    for (int i = 0; i < N; i++) begin
      if (b[i]) d = i;
    end
    return d;
  endfunction

  task automatic start_div(input logic [DW-1:0] dd, input logic [N-1:0] bb);
    int n;
    n = 0;
    while (!in_ready && n < TMO) begin
      @(posedge clk); #1;
      n++;
    end
    dividend = dd;
    divisor  = bb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_div(input logic [DW-1:0] dd, input logic [N-1:0] bb,
                         output logic [DW-1:0] q, output logic [RW-1:0] r,
                         output logic dz, output int lat);
    start_div(dd, bb);
    lat = 1;
    while (!out_valid && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [DW-1:0] q, dd, big;
  logic [RW-1:0] r, rr, m;
  logic [N-1:0]  a, b;
  logic          dz;
  int            lat;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready", DW'(in_ready), DW'(1));
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_quotient", quotient, '0);
    check("rst_remainder", DW'(remainder), '0);
    check("rst_dbz", DW'(div_by_zero), DW'(0));

    // (x^3+1) / (x+1) = x^2+x+1
    run_div(DW'(9), N'(3), q, r, dz, lat);
    check("d9b3_q", q, DW'(7));
    check("d9b3_r", DW'(r), DW'(0));
    check("d9b3_dbz", DW'(dz), DW'(0));
    check("d9b3_lat", DW'(lat), DW'(LAT_NZ));

    run_div(DW'(5), N'(2), q, r, dz, lat);
    check("d5b2_q", q, DW'(2));
    check("d5b2_r", DW'(r), DW'(1));

    run_div(DW'(32'h1234_5678), N'(0), q, r, dz, lat);
    check("bz_q", q, '0);
    check("bz_r", DW'(r), '0);
    check("bz_dbz", DW'(dz), DW'(1));
    check("bz_lat", DW'(lat), DW'(1));

    big = '1;
    run_div(big, N'(1), q, r, dz, lat);
    check("b1_q", q, big);
    check("b1_r", DW'(r), '0);

    // Top-degree divisor on the top dividend coefficient.
    dd = DW'(1) << (DW - 1);
    b  = N'(1) << (N - 1);
    run_div(dd, b, q, r, dz, lat);
    check("bmsb_q", q, DW'(1) << (N - 1));
    check("bmsb_r", DW'(r), '0);
    check("bmsb_lat", DW'(lat), DW'(LAT_NZ));

    for (int i = 0; i < NRND; i++) begin
      a = rnd_n();
      b = rnd_n();
      if (b == '0) b = N'(1);
      run_div(clmul(a, b), b, q, r, dz, lat);
      check("prod_q", q, DW'(a));
      check("prod_r", DW'(r), '0);
    end

    for (int i = 0; i < NRND; i++) begin
      a = rnd_n();
      b = rnd_n();
      if (i % 4 == 0) b = b >> (i % 100);
      if (b == '0) b = N'(3);
      m = '0;
      for (int k = 0; k < deg(b); k++) m[k] = 1'b1;
      rr = RW'(rnd_n()) & m;
      run_div(clmul(a, b) ^ DW'(rr), b, q, r, dz, lat);
      check("rem_q", q, DW'(a));
      check("rem_r", DW'(r), DW'(rr));
    end

    // Hold the result with out_ready low; new offers must be ignored.
    start_div(DW'(9), N'(3));
    lat = 1;
    while (!out_valid && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
    check("hold_lat", DW'(lat), DW'(LAT_NZ));
    dividend = '1;
    divisor  = N'(1);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_q", quotient, DW'(7));
      check("hold_r", DW'(remainder), '0);
      check("hold_valid", DW'(out_valid), DW'(1));
      check("hold_ready", DW'(in_ready), DW'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("rel_in_ready", DW'(in_ready), DW'(1));
    check("rel_out_valid", DW'(out_valid), DW'(0));

    // Reset mid-division, then a clean division.
    start_div(DW'(5), N'(2));
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready", DW'(in_ready), DW'(1));
    check("mid_rst_out_valid", DW'(out_valid), DW'(0));
    check("mid_rst_q", quotient, '0);
    run_div(DW'(9), N'(3), q, r, dz, lat);
    check("post_rst_q", q, DW'(7));
    check("post_rst_r", DW'(r), '0);
    check("post_rst_lat", DW'(lat), DW'(LAT_NZ));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
